counter_limit_shadowed: RTL
===========================

Name: counter_limit_shadowed

Overview:
- Parametrised successor of the basic zero-to-limit counter used across the LCD timing core.
- Counts 0..limit-1 with:
  - a shadowed, glitch-free limit update;
  - free-run and one-shot modes;
  - a start/stop control FSM;
  - a combinational terminal-count output, so instances cascade (horizontal counter drives the vertical counter's enable).
- Sits under the LCD timing controller as the building block for pixel, line and frame counters.

Parameters:
- C_WIDTH, 11, width of count and limit (max period 2^C_WIDTH-1).
- C_RESET_LIMIT, 0, value loaded into the active and pending limit registers on reset.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iEn  input  1  count enable; the counter advances only in cycles where iEn=1.
- iStart  input  1  single-cycle pulse; IDLE/DONE -> RUN.
- iStop  input  1  single-cycle pulse; RUN -> IDLE, count cleared.
- iOneShot  input  1  mode, sampled on the start-accept cycle: 1=one-shot, 0=free-run.
- iLimit  input  C_WIDTH  new period value.
- iLimitWr  input  1  write strobe; captures iLimit into the pending register.
- oCount  output  C_WIDTH  current count.
- oTc  output  1  terminal count; combinational.
- oBusy  output  1  state==RUN.
- oDone  output  1  state==DONE.
- oLimit  output  C_WIDTH  active limit.

Behaviour:
- Reset (iRst=1, asynchronous):
  - state=IDLE, oCount=0, mode register=0.
  - Active and pending limits = C_RESET_LIMIT.
  - Pending-valid flag = 0.
- Active limit L:
  - Effective period P = max(L,1); L=0 and L=1 both mean period 1.
  - Count stays at 0, and oTc fires on every enabled RUN cycle.
- oTc = (state==RUN) & iEn & (oCount == P-1). It is combinational so it can drive the next counter's iEn in the same cycle.
- IDLE:
  - oCount held at 0.
  - iStart=1 -> RUN next cycle; mode register <= iOneShot.
  - iStop is ignored.
- RUN:
  - iEn=1 and oCount<P-1: oCount+1.
  - iEn=1 and oCount==P-1 (oTc): oCount <= 0.
    - Free-run mode: stay in RUN.
    - One-shot mode: -> DONE.
  - iEn=0: hold.
  - iStart is ignored in RUN.
- DONE:
  - oCount=0, oDone=1.
  - iStart -> RUN with a fresh mode sample.
  - iStop -> IDLE.
- iStop in RUN: -> IDLE, oCount <= 0 next cycle. iStop wins over a same-cycle oTc; the state goes to IDLE, not DONE.
- iStart and iStop in the same cycle: iStop wins.
- Limit shadowing:
  - iLimitWr=1: pending <= iLimit, valid <= 1. A later write before transfer overwrites the pending value.
  - Transfer pending -> active and clear valid:
    - in any cycle state!=RUN, or
    - in a RUN cycle with oTc=1.
  - The new limit applies from the next count (period boundary only). The active limit never changes mid-period.
  - iLimitWr in the same cycle as a transfer: the newly written value becomes pending (valid=1). The previously pending value transfers.
  - Limit-write latency: in IDLE, a write appears on oLimit 2 cycles after the strobe.
- Width: all compares are at C_WIDTH bits, with P-1 computed without underflow. oCount never exceeds P-1 except transiently when L is written smaller. The shadowing makes that impossible in RUN.
- Latency:
  - iStart -> oBusy: 1 cycle.
  - First increment on the first enabled cycle in RUN.
- Reset mid-operation: immediate return to the reset values. Any pending limit is lost.

Decomposition:
- Shared package (lcd_tim_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants MODE_FREE=0, MODE_ONESHOT=1.
- One natural sub-module: limit_shadow_reg, holding the pending/active registers, the valid flag and the transfer logic, with a transfer-request input.
- The counter and FSM stay in the top level.

Test Plan:
- Free-run: limit 5 written in IDLE, iStart, iOneShot=0, iEn=1 continuous -> oCount 0,1,2,3,4,0,1...; oTc high exactly when oCount=4.
- One-shot with gated enable: limit 3, iOneShot=1, iEn toggling 1/0 -> count 0,0,1,1,2 then DONE, oDone=1, oBusy=0, oCount=0; a further iStart restarts.
- Shadowed limit: running with limit 8, write 4 while oCount=2 -> count continues to 7, oLimit changes to 4 on the wrap, next period 0..3.
- Degenerate limits: limit 0 and limit 1 -> oCount stays 0 and oTc=1 every enabled RUN cycle; oTc=0 while iEn=0.
- Collisions: iStop coincident with oTc in one-shot -> IDLE, not DONE; iStart+iStop together in IDLE -> stays IDLE.
- Async reset: assert iRst mid-count (oCount=6) between clock edges -> oCount=0, state IDLE, oLimit=C_RESET_LIMIT immediately; cascaded pair (H limit 4 driving V iEn, V limit 3) -> V increments once per 4 H counts, V oTc after 12 cycles.

Source files
------------

// File: rtl/lcd_tim_pkg.sv
// Shared definitions for the LCD timing counters: FSM state encoding and run modes.
package lcd_tim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/limit_shadow_reg.sv
// Double-buffered period limit: writes land in a pending register and move to the
// active register only when the owner requests a transfer (period boundary or idle).
module limit_shadow_reg #(
    parameter int unsigned C_WIDTH       = 11,
    parameter int unsigned C_RESET_LIMIT = 0
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [C_WIDTH-1:0] iLimit,
    input  logic               iLimitWr,
    input  logic               iXfer,
    output logic [C_WIDTH-1:0] oLimit
);

    localparam logic [C_WIDTH-1:0] RESET_LIMIT = C_WIDTH'(C_RESET_LIMIT);

    logic [C_WIDTH-1:0] active_q, active_d;
    logic [C_WIDTH-1:0] pending_q, pending_d;
    logic               valid_q, valid_d;

    // A write in a transfer cycle becomes the new pending value; the old one still moves.
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        if (iXfer && valid_q) begin
            active_d = pending_q;
            valid_d  = 1'b0;
        end
        if (iLimitWr) begin
            pending_d = iLimit;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            active_q  <= RESET_LIMIT;
            pending_q <= RESET_LIMIT;
            valid_q   <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    assign oLimit = active_q;

endmodule

// File: rtl/counter_limit_shadowed.sv
// Zero-to-limit counter with shadowed limit, free-run/one-shot modes and start/stop FSM.
// oTc is combinational so a chain of instances can cascade enables within one cycle.
module counter_limit_shadowed
    import lcd_tim_pkg::*;
#(
    parameter int unsigned C_WIDTH       = 11,
    parameter int unsigned C_RESET_LIMIT = 0
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iOneShot,
    input  logic [C_WIDTH-1:0] iLimit,
    input  logic               iLimitWr,
    output logic [C_WIDTH-1:0] oCount,
    output logic               oTc,
    output logic               oBusy,
    output logic               oDone,
    output logic [C_WIDTH-1:0] oLimit
);

    state_e             state_q, state_d;
    logic [C_WIDTH-1:0] count_q, count_d;
    logic               mode_q, mode_d;
    logic [C_WIDTH-1:0] active_limit;
    logic [C_WIDTH-1:0] last_count;
    logic               xfer;

    limit_shadow_reg #(
        .C_WIDTH       (C_WIDTH),
        .C_RESET_LIMIT (C_RESET_LIMIT)
    ) u_limit (
        .iClk     (iClk),
        .iRst     (iRst),
        .iLimit   (iLimit),
        .iLimitWr (iLimitWr),
        .iXfer    (xfer),
        .oLimit   (active_limit)
    );

    // Limits 0 and 1 both give a single-state period, so P-1 saturates at zero.
    assign last_count = (active_limit == '0) ? '0 : active_limit - C_WIDTH'(1);
    assign oTc        = (state_q == ST_RUN) && iEn && (count_q == last_count);
    assign xfer       = (state_q != ST_RUN) || oTc;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (iStart && !iStop) begin
                    state_d = ST_RUN;
                    mode_d  = iOneShot;
                end
            end
            ST_RUN: begin
                if (iStop) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (oTc) begin
                    count_d = '0;
                    if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
                end else if (iEn) begin
                    count_d = count_q + C_WIDTH'(1);
                end
            end
            ST_DONE: begin
                count_d = '0;
                if (iStop) begin
                    state_d = ST_IDLE;
                end else if (iStart) begin
                    state_d = ST_RUN;
                    mode_d  = iOneShot;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mode_q  <= MODE_FREE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    assign oCount = count_q;
    assign oBusy  = (state_q == ST_RUN);
    assign oDone  = (state_q == ST_DONE);
    assign oLimit = active_limit;

endmodule
